dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Arbitrates the single data-RAM port between CPU load/store traffic and UART programmer (upg_*) writes.
- Sits between the CPU top-level datapath and the `memory` block.
- Sequences the RAM's one-cycle synchronous read latency into a CPU stall.
- Holds the CPU stalled for the whole programming session (upg_done_i low).

Parameters:
ADDR_W, 14, word-address width of data RAM
DATA_W, 32, data width
UPG_ADDR_W, 15, programmer address width; MSB=1 selects data RAM, MSB=0 selects instruction ROM

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_rd_req  in  1  CPU load this cycle
cpu_wr_req  in  1  CPU store this cycle
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  load data to CPU
cpu_stall  out  1  freeze PC/pipeline
upg_wen_i  in  1  programmer write strobe
upg_adr_i  in  UPG_ADDR_W  programmer address
upg_dat_i  in  DATA_W  programmer data
upg_done_i  in  1  1 = programming finished / run mode
ram_wen  out  1  RAM write enable
ram_adr  out  ADDR_W  RAM word address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after address
prog_mode  out  1  1 while in S_PROG
err_conflict  out  1  sticky: cpu_rd_req and cpu_wr_req both high
perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature)
perf_access_cnt  out  32  CPU access counter (see Optional Feature)

Behaviour:
- One clock; reset synchronous active-high. All registers update on posedge clk.
- Reset values:
  - state = S_IDLE; rdata_q = 0; err_conflict = 0; counters = 0.
  - While rst = 1: ram_wen = 0, cpu_stall = 0, prog_mode = 0.
- States: S_IDLE, S_RD_WAIT, S_PROG.
- S_IDLE:
  - upg_done_i = 0 has top priority: next state S_PROG, cpu_stall = 1, ram_wen = 0 this cycle.
  - Else if cpu_wr_req: ram_wen = 1, ram_adr = cpu_addr, ram_wdata = cpu_wdata. No stall; stay in S_IDLE.
  - Else if cpu_rd_req: ram_adr = cpu_addr, ram_wen = 0, cpu_stall = 1; next state S_RD_WAIT.
  - cpu_rd_req and cpu_wr_req together: the write is performed, the read is ignored, and err_conflict sets (held until rst).
- S_RD_WAIT:
  - ram_adr held at cpu_addr; cpu_rdata = ram_rdata combinationally; rdata_q <= ram_rdata; cpu_stall = 0.
  - Next state S_IDLE, so load latency = 2 cycles with exactly 1 stall cycle.
  - If upg_done_i = 0 here, the read is aborted: cpu_stall = 1, rdata_q is not updated, next state S_PROG.
- S_PROG:
  - prog_mode = 1; cpu_stall = 1 every cycle; CPU requests ignored.
  - ram_wen = upg_wen_i & upg_adr_i[UPG_ADDR_W-1]; ram_adr = upg_adr_i[ADDR_W-1:0]; ram_wdata = upg_dat_i.
  - Writes with MSB = 0 (instruction ROM) never reach the RAM.
  - upg_done_i = 1: next state S_IDLE. cpu_stall stays 1 in that exit cycle and first drops in S_IDLE.
- Outside S_RD_WAIT, cpu_rdata = rdata_q.
- When not writing, ram_wdata = cpu_wdata.
- Illegal state encoding: recover to S_IDLE.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments every cycle cpu_stall = 1 and rst = 0.
  - perf_access_cnt increments on each accepted CPU write (S_IDLE) and each completed read (S_RD_WAIT not aborted).
  - Both wrap modulo 2^32 and clear on rst.
- Undefined: both outputs tied to 0, no counter registers.

Test Plan:
- Reset with upg_done_i = 1, then release → state S_IDLE, cpu_stall = 0, ram_wen = 0, prog_mode = 0, cpu_rdata = 0.
- cpu_wr_req, cpu_addr = 0x0010, cpu_wdata = 0xDEADBEEF → same cycle ram_wen = 1, ram_adr = 0x0010, ram_wdata = 0xDEADBEEF, cpu_stall = 0.
- cpu_rd_req, addr 0x0010 → cycle0 cpu_stall = 1, ram_adr = 0x0010; cycle1 cpu_stall = 0, cpu_rdata = 0xDEADBEEF; cycle2 cpu_rdata still 0xDEADBEEF.
- upg_done_i = 0; upg write adr 0x4005, data 0x12345678 → ram_wen = 1, ram_adr = 0x0005; upg write adr 0x0005 → ram_wen = 0; cpu_stall = 1 throughout; upg_done_i = 1 → cpu_stall = 0 one cycle later.
- upg_done_i drops during S_RD_WAIT → cpu_stall = 1, rdata_q unchanged, prog_mode = 1 next cycle; with macro, perf_access_cnt not incremented.
- cpu_rd_req = cpu_wr_req = 1, addr 0x0003 → write issued (ram_wen = 1), no stall, err_conflict = 1 and held until rst.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-RAM port between CPU loads/stores and the UART programmer.
// Optional performance counters are built when DMEM_ARB_PERF_CNT_EN is defined.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int UPG_ADDR_W = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_rd_req,
    input  logic                  cpu_wr_req,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  upg_wen_i,
    input  logic [UPG_ADDR_W-1:0] upg_adr_i,
    input  logic [DATA_W-1:0]     upg_dat_i,
    input  logic                  upg_done_i,
    output logic                  ram_wen,
    output logic [ADDR_W-1:0]     ram_adr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  prog_mode,
    output logic                  err_conflict,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_access_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_PROG    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              wen, stall;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        wen       = 1'b0;
        stall     = 1'b0;
        ram_adr   = cpu_addr;
        ram_wdata = cpu_wdata;
        cpu_rdata = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (!upg_done_i) begin
                    stall   = 1'b1;
                    state_d = S_PROG;
                end else if (cpu_wr_req) begin
                    wen = 1'b1;
                    if (cpu_rd_req) err_d = 1'b1;
                end else if (cpu_rd_req) begin
                    stall   = 1'b1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                cpu_rdata = ram_rdata;
                // A programming session pre-empts the pending load; its data is dropped.
                if (!upg_done_i) begin
                    stall   = 1'b1;
                    state_d = S_PROG;
                end else begin
                    rdata_d = ram_rdata;
                    state_d = S_IDLE;
                end
            end
            S_PROG: begin
                stall   = 1'b1;
                wen     = upg_wen_i & upg_adr_i[UPG_ADDR_W-1];
                ram_adr = upg_adr_i[ADDR_W-1:0];
                if (wen) ram_wdata = upg_dat_i;
                if (upg_done_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Control outputs are forced quiet for the whole reset cycle.
    assign ram_wen      = wen & ~rst;
    assign cpu_stall    = stall & ~rst;
    assign prog_mode    = (state_q == S_PROG) & ~rst;
    assign err_conflict = err_q;

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, access_cnt_q;
    logic        access;

    assign access = upg_done_i &
                    (((state_q == S_IDLE) & cpu_wr_req) | (state_q == S_RD_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            access_cnt_q <= '0;
        end else begin
            if (cpu_stall) stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (access)    access_cnt_q <= access_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_access_cnt = access_cnt_q;
`else
    assign perf_stall_cnt  = '0;
    assign perf_access_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a behavioural one-cycle-latency RAM.
module tb_dmem_port_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int UPG_ADDR_W = 15;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cpu_rd_req, cpu_wr_req;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata, cpu_rdata;
    logic                  cpu_stall;
    logic                  upg_wen_i;
    logic [UPG_ADDR_W-1:0] upg_adr_i;
    logic [DATA_W-1:0]     upg_dat_i;
    logic                  upg_done_i;
    logic                  ram_wen;
    logic [ADDR_W-1:0]     ram_adr;
    logic [DATA_W-1:0]     ram_wdata, ram_rdata;
    logic                  prog_mode, err_conflict;
    logic [31:0]           perf_stall_cnt, perf_access_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .UPG_ADDR_W(UPG_ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
        .upg_done_i(upg_done_i),
        .ram_wen(ram_wen), .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .prog_mode(prog_mode), .err_conflict(err_conflict),
        .perf_stall_cnt(perf_stall_cnt), .perf_access_cnt(perf_access_cnt)
    );

    // Synchronous RAM: read data is the old contents at the address presented last cycle.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_adr] <= ram_wdata;
        ram_rdata <= mem[ram_adr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Expected counter value: the model count when counters are built, else zero.
    function automatic logic [31:0] pc(input logic [31:0] v);
`ifdef DMEM_ARB_PERF_CNT_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        cpu_rd_req = 1'b0;
        cpu_wr_req = 1'b0;
        upg_wen_i  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
        rst        = 1'b1;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        upg_adr_i  = '0;
        upg_dat_i  = '0;
        upg_done_i = 1'b0;
        idle_inputs();

        // Reset with programmer active: control outputs must still be quiet.
        tick(); settle();
        check("rst_stall", cpu_stall, 0);
        check("rst_wen",   ram_wen,   0);
        check("rst_prog",  prog_mode, 0);

        upg_done_i = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("idle_stall", cpu_stall, 0);
        check("idle_wen",   ram_wen,   0);
        check("idle_prog",  prog_mode, 0);
        check("idle_rdata", cpu_rdata, 0);
        check("idle_err",   err_conflict, 0);
        check("idle_pstall",  perf_stall_cnt,  0);
        check("idle_paccess", perf_access_cnt, 0);

        // Store: same-cycle RAM write, no stall.
        tick();
        cpu_wr_req = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 32'hDEADBEEF;
        settle();
        check("wr_wen",   ram_wen,   1);
        check("wr_adr",   ram_adr,   32'h0010);
        check("wr_wdata", ram_wdata, 32'hDEADBEEF);
        check("wr_stall", cpu_stall, 0);

        // Load: one stall cycle, data on the second cycle, then held.
        tick();
        cpu_wr_req = 1'b0; cpu_rd_req = 1'b1; cpu_wdata = 32'h0;
        settle();
        check("rd0_stall", cpu_stall, 1);
        check("rd0_adr",   ram_adr,   32'h0010);
        check("rd0_wen",   ram_wen,   0);
        tick(); settle();
        check("rd1_stall", cpu_stall, 0);
        check("rd1_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rd1_adr",   ram_adr,   32'h0010);
        tick();
        cpu_rd_req = 1'b0;
        settle();
        check("rd2_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rd2_stall", cpu_stall, 0);
        check("rd2_pstall",  perf_stall_cnt,  pc(1));
        check("rd2_paccess", perf_access_cnt, pc(2));

        // Programming session.
        tick();
        upg_done_i = 1'b0;
        settle();
        check("pg0_stall", cpu_stall, 1);
        check("pg0_wen",   ram_wen,   0);
        tick();
        upg_wen_i = 1'b1; upg_adr_i = 15'h4005; upg_dat_i = 32'h12345678;
        settle();
        check("pg1_prog",  prog_mode, 1);
        check("pg1_stall", cpu_stall, 1);
        check("pg1_wen",   ram_wen,   1);
        check("pg1_adr",   ram_adr,   32'h0005);
        check("pg1_wdata", ram_wdata, 32'h12345678);
        tick();
        upg_adr_i = 15'h0005; upg_dat_i = 32'hCAFEF00D;
        cpu_wr_req = 1'b1; cpu_addr = 14'h0007;
        settle();
        check("pg2_rom_wen", ram_wen,   0);
        check("pg2_stall",   cpu_stall, 1);
        tick();
        cpu_wr_req = 1'b0; upg_wen_i = 1'b0; upg_done_i = 1'b1;
        settle();
        check("pg3_exit_stall", cpu_stall, 1);
        check("pg3_exit_prog",  prog_mode, 1);
        tick(); settle();
        check("pg4_stall", cpu_stall, 0);
        check("pg4_prog",  prog_mode, 0);
        check("pg4_pstall",  perf_stall_cnt,  pc(5));
        check("pg4_paccess", perf_access_cnt, pc(2));

        // Read back the programmed word; the ROM-targeted write left it unchanged.
        tick();
        cpu_rd_req = 1'b1; cpu_addr = 14'h0005;
        settle();
        check("rb0_stall", cpu_stall, 1);
        tick(); settle();
        check("rb1_rdata", cpu_rdata, 32'h12345678);
        tick();
        cpu_rd_req = 1'b0;

        // Load aborted by programmer in the wait cycle.
        cpu_rd_req = 1'b1; cpu_addr = 14'h0010;
        settle();
        check("ab0_stall", cpu_stall, 1);
        tick();
        upg_done_i = 1'b0;
        settle();
        check("ab1_stall", cpu_stall, 1);
        tick();
        cpu_rd_req = 1'b0;
        settle();
        check("ab2_prog",  prog_mode, 1);
        check("ab2_stall", cpu_stall, 1);
        check("ab2_rdata", cpu_rdata, 32'h12345678);
        tick();
        upg_done_i = 1'b1;
        settle();
        check("ab3_stall", cpu_stall, 1);
        tick(); settle();
        check("ab4_stall", cpu_stall, 0);
        check("ab4_rdata", cpu_rdata, 32'h12345678);
        check("ab4_pstall",  perf_stall_cnt,  pc(10));
        check("ab4_paccess", perf_access_cnt, pc(3));

        // Simultaneous load and store: store wins, error flag sticks.
        tick();
        cpu_rd_req = 1'b1; cpu_wr_req = 1'b1; cpu_addr = 14'h0003; cpu_wdata = 32'hA5A5A5A5;
        settle();
        check("cf_wen",   ram_wen,   1);
        check("cf_adr",   ram_adr,   32'h0003);
        check("cf_stall", cpu_stall, 0);
        tick();
        idle_inputs();
        settle();
        check("cf_err",   err_conflict, 1);
        check("cf_next_stall", cpu_stall, 0);
        check("cf_paccess", perf_access_cnt, pc(4));
        tick(); tick(); settle();
        check("cf_err_held", err_conflict, 1);

        // Reset clears the sticky flag and the counters.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst2_err",     err_conflict,    0);
        check("rst2_pstall",  perf_stall_cnt,  0);
        check("rst2_paccess", perf_access_cnt, 0);
        check("rst2_rdata",   cpu_rdata,       0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
